// File: rtl/basic_i2c_slave.sv
`timescale 1ns/1ps
// I2C target with a simple register-bus front end; oversamples SCL/SDA and drives SDA open-drain.
// Optional feature: define I2C_SLAVE_AUTO_INC_EN to advance reg_addr_o after every data byte.
module basic_i2c_slave #(
    parameter logic [6:0]  DEV_ADDR    = 7'h55,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       i2c_serial_clk,
    inout  wire        i2c_serial_data,
    output logic [7:0] reg_addr_o,
    output logic [7:0] reg_wdata_o,
    output logic       reg_wr_o,
    output logic       reg_rd_o,
    input  logic [7:0] reg_rdata_i,
    output logic       busy_o
);
    localparam int unsigned DW = 8;
    localparam int unsigned CW = 4;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_REG,
        S_REG_ACK,
        S_WDATA,
        S_WDATA_ACK,
        S_RDATA,
        S_RDATA_ACK
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_d;
    logic                   sda_d;

    // Input synchronizers plus one extra delayed copy for edge detection
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], i2c_serial_clk};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], i2c_serial_data};
            scl_d    <= scl_sync[SYNC_STAGES-1];
            sda_d    <= sda_sync[SYNC_STAGES-1];
        end
    end

    logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & ~sda_s & sda_d;
    assign stop_det  = scl_s & scl_d & sda_s & ~sda_d;

    state_t          state, state_nxt;
    logic [CW-1:0]   bit_cnt, bit_cnt_nxt;
    logic [DW-1:0]   rx_shift, rx_nxt, rx_shifted;
    logic [DW-1:0]   tx_shift, tx_nxt;
    logic [DW-1:0]   addr_nxt, wdata_nxt;
    logic            sda_drive, drive_nxt;
    logic            rw, rw_nxt;
    logic            wr_nxt, rd_nxt, busy_nxt;

    assign rx_shifted = {rx_shift[DW-2:0], sda_s};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= S_IDLE;
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            sda_drive   <= 1'b0;
            rw          <= 1'b0;
            reg_addr_o  <= '0;
            reg_wdata_o <= '0;
            reg_wr_o    <= 1'b0;
            reg_rd_o    <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            state       <= state_nxt;
            bit_cnt     <= bit_cnt_nxt;
            rx_shift    <= rx_nxt;
            tx_shift    <= tx_nxt;
            sda_drive   <= drive_nxt;
            rw          <= rw_nxt;
            reg_addr_o  <= addr_nxt;
            reg_wdata_o <= wdata_nxt;
            reg_wr_o    <= wr_nxt;
            reg_rd_o    <= rd_nxt;
            busy_o      <= busy_nxt;
        end
    end

    // Next-state logic; START/STOP take priority over every protocol state
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        rx_nxt      = rx_shift;
        tx_nxt      = tx_shift;
        drive_nxt   = sda_drive;
        rw_nxt      = rw;
        addr_nxt    = reg_addr_o;
        wdata_nxt   = reg_wdata_o;
        wr_nxt      = 1'b0;
        rd_nxt      = 1'b0;
        busy_nxt    = busy_o;

        // Read data is captured the cycle after the request strobe
        if (reg_rd_o) begin
            tx_nxt = reg_rdata_i;
        end

        if (start_det) begin
            state_nxt   = S_ADDR;
            bit_cnt_nxt = '0;
            busy_nxt    = 1'b0;
            drive_nxt   = 1'b0;
        end else if (stop_det) begin
            state_nxt = S_IDLE;
            busy_nxt  = 1'b0;
            drive_nxt = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    drive_nxt = 1'b0;
                end
                S_ADDR, S_REG, S_WDATA: begin
                    if (scl_rise) begin
                        rx_nxt      = rx_shifted;
                        bit_cnt_nxt = bit_cnt + CW'(1);
                        if (bit_cnt == CW'(7)) begin
                            bit_cnt_nxt = '0;
                            if (state == S_ADDR) begin
                                if (rx_shifted[7:1] == DEV_ADDR) begin
                                    state_nxt = S_ADDR_ACK;
                                    busy_nxt  = 1'b1;
                                    rw_nxt    = rx_shifted[0];
                                    rd_nxt    = rx_shifted[0];
                                end else begin
                                    state_nxt = S_IDLE;
                                end
                            end else if (state == S_REG) begin
                                addr_nxt  = rx_shifted;
                                state_nxt = S_REG_ACK;
                            end else begin
                                wdata_nxt = rx_shifted;
                                wr_nxt    = 1'b1;
                                state_nxt = S_WDATA_ACK;
                            end
                        end
                    end
                end
                // bit_cnt 0: waiting for end of 8th pulse; 1: holding ACK for the 9th
                S_ADDR_ACK, S_REG_ACK, S_WDATA_ACK: begin
                    if (scl_fall) begin
                        if (bit_cnt == '0) begin
                            drive_nxt   = 1'b1;
                            bit_cnt_nxt = CW'(1);
                        end else begin
                            drive_nxt   = 1'b0;
                            bit_cnt_nxt = '0;
                            if (state == S_ADDR_ACK) begin
                                if (rw) begin
                                    state_nxt = S_RDATA;
                                    drive_nxt = ~tx_shift[DW-1];
                                end else begin
                                    state_nxt = S_REG;
                                end
                            end else begin
                                state_nxt = S_WDATA;
`ifdef I2C_SLAVE_AUTO_INC_EN
                                if (state == S_WDATA_ACK) begin
                                    addr_nxt = reg_addr_o + DW'(1);
                                end
`endif
                            end
                        end
                    end
                end
                // bit_cnt 8 means a reloaded byte whose MSB is not yet on the bus
                S_RDATA: begin
                    if (scl_fall) begin
                        if (bit_cnt == CW'(8)) begin
                            drive_nxt   = ~tx_shift[DW-1];
                            bit_cnt_nxt = '0;
                        end else if (bit_cnt == CW'(7)) begin
                            drive_nxt   = 1'b0;
                            bit_cnt_nxt = '0;
                            state_nxt   = S_RDATA_ACK;
                        end else begin
                            tx_nxt      = {tx_shift[DW-2:0], 1'b0};
                            drive_nxt   = ~tx_shift[DW-2];
                            bit_cnt_nxt = bit_cnt + CW'(1);
                        end
                    end
                end
                S_RDATA_ACK: begin
                    if (scl_rise) begin
                        if (!sda_s) begin
                            rd_nxt      = 1'b1;
                            bit_cnt_nxt = CW'(8);
                            state_nxt   = S_RDATA;
`ifdef I2C_SLAVE_AUTO_INC_EN
                            addr_nxt    = reg_addr_o + DW'(1);
`endif
                        end else begin
                            state_nxt = S_IDLE;
                            busy_nxt  = 1'b0;
                        end
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    drive_nxt = 1'b0;
                end
            endcase
        end
    end

    assign i2c_serial_data = sda_drive ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_basic_i2c_slave.sv
`timescale 1ns/1ps
// Bench for basic_i2c_slave: directed and random I2C frames checked against a register-level model.
module tb_basic_i2c_slave;
`ifdef I2C_SLAVE_AUTO_INC_EN
    localparam bit AUTO_INC = 1'b1;
`else
    localparam bit AUTO_INC = 1'b0;
`endif

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       scl     = 1'b1;
    logic       sda_low = 1'b0;
    wire        sda;
    logic [7:0] reg_addr, reg_wdata, reg_rdata;
    logic       reg_wr, reg_rd, busy;

    assign sda = sda_low ? 1'b0 : 1'bz;
    pullup (sda);

    always #5 clk = ~clk;

    basic_i2c_slave #(.DEV_ADDR(7'h55), .SYNC_STAGES(2)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .i2c_serial_clk (scl),
        .i2c_serial_data(sda),
        .reg_addr_o     (reg_addr),
        .reg_wdata_o    (reg_wdata),
        .reg_wr_o       (reg_wr),
        .reg_rd_o       (reg_rd),
        .reg_rdata_i    (reg_rdata),
        .busy_o         (busy)
    );

    // user_mem is the register file behind the bus; model_mem is what it should contain
    logic [7:0]  user_mem  [256];
    logic [7:0]  model_mem [256];
    logic [7:0]  model_ptr = 8'h00;
    logic [15:0] exp_wr[$];
    logic [7:0]  exp_rd[$];
    logic [7:0]  tx_data[4];
    logic [7:0]  last_rd;
    logic        wr_prev = 1'b0, rd_prev = 1'b0;
    logic [15:0] e_wr;
    logic [7:0]  e_rd;
    int          checks = 0, errors = 0, wr_count = 0, rd_count = 0;

    assign reg_rdata = user_mem[reg_addr];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Strobe checker: every register-bus strobe must match the next expected access
    always @(negedge clk) begin
        if (!rst_n) begin
            wr_prev = 1'b0;
            rd_prev = 1'b0;
        end else begin
            if (reg_wr || reg_rd) chk("strobe_excl", 8'(reg_wr & reg_rd), 8'h00);
            if (reg_wr) begin
                wr_count++;
                user_mem[reg_addr] = reg_wdata;
                chk("wr_pulse_len", 8'(wr_prev), 8'h00);
                if (exp_wr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wr_unexpected: got addr %02h data %02h expected no write", reg_addr, reg_wdata);
                end else begin
                    e_wr = exp_wr.pop_front();
                    chk("wr_addr", reg_addr, e_wr[15:8]);
                    chk("wr_data", reg_wdata, e_wr[7:0]);
                end
            end
            if (reg_rd) begin
                rd_count++;
                chk("rd_pulse_len", 8'(rd_prev), 8'h00);
                if (exp_rd.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_unexpected: got addr %02h expected no read", reg_addr);
                end else begin
                    e_rd = exp_rd.pop_front();
                    chk("rd_addr", reg_addr, e_rd);
                end
            end
            wr_prev = reg_wr;
            rd_prev = reg_rd;
        end
    end

    // One SCL pulse; master drives b (1 = release) and samples the bus mid-high
    task automatic bit_xfer(input logic b, output logic seen);
        #60 sda_low = ~b;
        #40 scl = 1'b1;
        #50 seen = sda;
        #50 scl = 1'b0;
    endtask

    task automatic do_start();
        if (scl) begin
            #50 sda_low = 1'b1;
        end else begin
            #60 sda_low = 1'b0;
            #40 scl = 1'b1;
            #50 sda_low = 1'b1;
        end
        #50 scl = 1'b0;
    endtask

    task automatic do_stop();
        #60 sda_low = 1'b1;
        #40 scl = 1'b1;
        #50 sda_low = 1'b0;
        #100;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], s);
        bit_xfer(1'b1, ack);
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, s);
            b[i] = s;
        end
        bit_xfer(nack, s);
    endtask

    task automatic finish_txn();
        do_stop();
        #200;
        chk("wr_pending", 8'(exp_wr.size()), 8'h00);
        chk("rd_pending", 8'(exp_rd.size()), 8'h00);
        chk("busy_idle", 8'(busy), 8'h00);
        chk("ptr_after", reg_addr, model_ptr);
        chk("sda_released", 8'(sda), 8'h01);
    endtask

    task automatic write_txn(input logic [6:0] dev, input logic [7:0] rp, input int n);
        logic ack;
        logic hit;
        hit = (dev == 7'h55);
        do_start();
        send_byte({dev, 1'b0}, ack);
        chk("addr_ack", 8'(ack), 8'(!hit));
        chk("busy_addr", 8'(busy), 8'(hit));
        send_byte(rp, ack);
        chk("reg_ack", 8'(ack), 8'(!hit));
        if (hit) model_ptr = rp;
        for (int i = 0; i < n; i++) begin
            if (hit) begin
                exp_wr.push_back({model_ptr, tx_data[i]});
                model_mem[model_ptr] = tx_data[i];
                if (AUTO_INC) model_ptr = model_ptr + 8'd1;
            end
            send_byte(tx_data[i], ack);
            chk("data_ack", 8'(ack), 8'(!hit));
        end
        finish_txn();
    endtask

    task automatic read_txn(input logic [7:0] rp, input int n);
        logic       ack;
        logic [7:0] b, a;
        do_start();
        send_byte(8'hAA, ack);
        chk("addr_ack", 8'(ack), 8'h00);
        send_byte(rp, ack);
        chk("reg_ack", 8'(ack), 8'h00);
        model_ptr = rp;
        do_start();
        for (int i = 0; i < n; i++) exp_rd.push_back(AUTO_INC ? 8'(rp + 8'(i)) : rp);
        send_byte(8'hAB, ack);
        chk("raddr_ack", 8'(ack), 8'h00);
        chk("busy_read", 8'(busy), 8'h01);
        for (int i = 0; i < n; i++) begin
            recv_byte(i == n - 1, b);
            a = AUTO_INC ? 8'(rp + 8'(i)) : rp;
            chk("rd_data", b, model_mem[a]);
            last_rd = b;
        end
        if (AUTO_INC) model_ptr = 8'(rp + 8'(n - 1));
        finish_txn();
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ack, s;
        logic [6:0] dev;
        logic [7:0] rp, pre_ff;
        int         wc0, rc0, kind, n;

        for (int i = 0; i < 256; i++) begin
            user_mem[i]  = 8'($urandom);
            model_mem[i] = user_mem[i];
        end

        // Reset state
        #22;
        chk("rst_addr", reg_addr, 8'h00);
        chk("rst_wdata", reg_wdata, 8'h00);
        chk("rst_wr", 8'(reg_wr), 8'h00);
        chk("rst_rd", 8'(reg_rd), 8'h00);
        chk("rst_busy", 8'(busy), 8'h00);
        chk("rst_sda", 8'(sda), 8'h01);
        #30 rst_n = 1'b1;
        #200;

        // Single write
        tx_data[0] = 8'hFF;
        write_txn(7'h55, 8'hAA, 1);
        chk("t1_mem", user_mem[8'hAA], 8'hFF);
        chk("t1_addr", reg_addr, 8'hAA);

        // Read with repeated START
        user_mem[8'hAA]  = 8'h3C;
        model_mem[8'hAA] = 8'h3C;
        rc0 = rd_count;
        read_txn(8'hAA, 1);
        chk("t2_byte", last_rd, 8'h3C);
        chk("t2_rd_once", 8'(rd_count - rc0), 8'h01);

        // Wrong address
        wc0 = wr_count;
        rc0 = rd_count;
        tx_data[0] = 8'h77;
        write_txn(7'h2A, 8'h12, 1);
        chk("t3_no_wr", 8'(wr_count - wc0), 8'h00);
        chk("t3_no_rd", 8'(rd_count - rc0), 8'h00);

        // Burst across the 8'hFF wrap
        pre_ff = user_mem[8'hFF];
        tx_data[0] = 8'h11; tx_data[1] = 8'h22; tx_data[2] = 8'h33;
        write_txn(7'h55, 8'hFE, 3);
        chk("t4_fe", user_mem[8'hFE], AUTO_INC ? 8'h11 : 8'h33);
        chk("t4_ff", user_mem[8'hFF], AUTO_INC ? 8'h22 : pre_ff);
        chk("t4_ptr", reg_addr, AUTO_INC ? 8'h01 : 8'hFE);

        // STOP right after the register byte, then a normal write
        wc0 = wr_count;
        write_txn(7'h55, 8'h10, 0);
        chk("t5_no_wr", 8'(wr_count - wc0), 8'h00);
        tx_data[0] = 8'h5A;
        write_txn(7'h55, 8'h20, 1);
        chk("t5_mem", user_mem[8'h20], 8'h5A);

        // Reset while the target is pulling SDA low during a read
        user_mem[8'h40]  = 8'h3C;
        model_mem[8'h40] = 8'h3C;
        do_start();
        send_byte(8'hAA, ack);
        chk("t6_addr_ack", 8'(ack), 8'h00);
        send_byte(8'h40, ack);
        chk("t6_reg_ack", 8'(ack), 8'h00);
        do_start();
        exp_rd.push_back(8'h40);
        send_byte(8'hAB, ack);
        chk("t6_raddr_ack", 8'(ack), 8'h00);
        #60 sda_low = 1'b0;
        #40 scl = 1'b1;
        #50 s = sda;
        chk("t6_bit7_low", 8'(s), 8'h00);
        rst_n = 1'b0;
        #1;
        chk("t6_sda_z", 8'(sda), 8'h01);
        chk("t6_busy", 8'(busy), 8'h00);
        chk("t6_addr", reg_addr, 8'h00);
        chk("t6_rd", 8'(reg_rd), 8'h00);
        chk("t6_wdata", reg_wdata, 8'h00);
        model_ptr = 8'h00;
        #49 scl = 1'b0;
        #40 rst_n = 1'b1;
        #100;
        do_stop();
        tx_data[0] = 8'hC3;
        write_txn(7'h55, 8'h33, 1);
        chk("t6_mem", user_mem[8'h33], 8'hC3);

        // Randomized traffic
        for (int t = 0; t < 24; t++) begin
            kind = $urandom_range(0, 5);
            n    = $urandom_range(1, 3);
            rp   = 8'($urandom);
            for (int i = 0; i < 4; i++) tx_data[i] = 8'($urandom);
            if (kind == 0) begin
                dev = 7'($urandom_range(0, 127));
                if (dev == 7'h55) dev = 7'h54;
                write_txn(dev, rp, n);
            end else if (kind <= 3) begin
                write_txn(7'h55, rp, n);
            end else begin
                read_txn(rp, n);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
